// File: rtl/word2byte_pkt.sv
// Serialises 16-bit words into framed bytes: header, hi/lo payload bytes, 8-bit checksum.
// Single-word holding register; all byte-side outputs decoded from registered state.
module word2byte_pkt #(
    parameter int unsigned PKT_WORDS = 4,
    parameter logic [7:0]  HEAD_BYTE = 8'h55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    output logic        b_rdy,
    output logic [7:0]  dout,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic        dout_sop,
    output logic        dout_eop
);

    typedef enum logic [2:0] {IDLE, HEAD, HI, LO, SUM} state_t;

    localparam logic [7:0] LAST_WORD = 8'(PKT_WORDS - 1);

    state_t      state_q, state_d;
    logic [15:0] word_q;
    logic        word_full_q, word_full_d;
    logic        live_q;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;

    // live_q keeps b_rdy low until the first edge after reset release
    assign b_rdy  = live_q & ~word_full_q;
    assign accept = din_vld & b_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            word_full_q <= 1'b0;
            live_q      <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            word_full_q <= word_full_d;
            live_q      <= 1'b1;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                word_q <= din;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        word_full_d = word_full_q;
        dout        = '0;
        dout_vld    = 1'b0;
        dout_sop    = 1'b0;
        dout_eop    = 1'b0;

        if (accept) begin
            word_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (word_full_q) begin
                    state_d = HEAD;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            HEAD: begin
                dout     = HEAD_BYTE;
                dout_vld = 1'b1;
                dout_sop = 1'b1;
                if (dout_rdy) begin
                    state_d = HI;
                end
            end
            HI: begin
                dout     = word_q[15:8];
                dout_vld = word_full_q;
                if (word_full_q && dout_rdy) begin
                    state_d = LO;
                    sum_d   = sum_q + word_q[15:8];
                end
            end
            LO: begin
                // word_full is always set here, so no accept can collide with the clear
                dout     = word_q[7:0];
                dout_vld = 1'b1;
                if (dout_rdy) begin
                    sum_d       = sum_q + word_q[7:0];
                    word_full_d = 1'b0;
                    if (cnt_q == LAST_WORD) begin
                        state_d = SUM;
                    end else begin
                        state_d = HI;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
            SUM: begin
                dout     = sum_q;
                dout_vld = 1'b1;
                dout_eop = 1'b1;
                if (dout_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/word2byte_pkt.md
WORD2BYTE_PKT -- requirements
Module: word2byte_pkt

Interface
REQ-001 SHALL provide parameter: PKT_WORDS, default 4, number of 16-bit payload words per frame (legal range 1..255).
REQ-002 SHALL provide parameter: HEAD_BYTE, default 8'h55, frame header byte.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: din  input  16  payload word from the upstream FIFO read side.
REQ-006 SHALL have port: din_vld  input  1  din valid.
REQ-007 SHALL have port: b_rdy  output  1  ready to the upstream FIFO; a word transfers on any rising edge where din_vld=1 and b_rdy=1.
REQ-008 SHALL have port: dout  output  8  frame byte.
REQ-009 SHALL have port: dout_vld  output  1  dout valid.
REQ-010 SHALL have port: dout_rdy  input  1  downstream ready; a byte transfers on any rising edge where dout_vld=1 and dout_rdy=1.
REQ-011 SHALL have port: dout_sop  output  1  high with the header byte only.
REQ-012 SHALL have port: dout_eop  output  1  high with the checksum byte only.

Function
REQ-013 SHALL emit each frame as: HEAD_BYTE, then for each of the PKT_WORDS words din[15:8] followed by din[7:0], then one checksum byte.
REQ-014 SHALL compute the checksum as the sum of all 2*PKT_WORDS payload bytes, truncated to 8 bits; the header byte SHALL NOT be included.
REQ-015 SHALL hold exactly one input word in a holding register with flag word_full.
REQ-016 SHALL drive b_rdy = !word_full once out of reset; din_vld while b_rdy=0 SHALL be ignored and SHALL NOT alter the holding register.
REQ-017 SHALL set word_full on a transfer edge and SHALL clear word_full on the edge where the low byte of that word transfers.
REQ-018 SHALL implement a Moore FSM with states IDLE, HEAD, HI, LO, SUM; dout, dout_vld, dout_sop and dout_eop SHALL be decoded from registered state only, with no combinational path from dout_rdy or din_vld.
REQ-019 IDLE: dout_vld=0; go to HEAD on the first edge where word_full=1; clear checksum and word counter on that edge.
REQ-020 HEAD: dout=HEAD_BYTE, dout_vld=1, dout_sop=1; go to HI on byte transfer.
REQ-021 HI: dout=word[15:8], dout_vld=word_full; go to LO on byte transfer; while word_full=0, dout_vld=0 and stay in HI.
REQ-022 LO: dout=word[7:0], dout_vld=1; on byte transfer go to SUM if the word counter equals PKT_WORDS-1, else go to HI and increment the counter.
REQ-023 SUM: dout=checksum, dout_vld=1, dout_eop=1; go to IDLE on byte transfer.
REQ-024 While dout_vld=1 and dout_rdy=0, dout, dout_sop and dout_eop SHALL remain stable and the state SHALL NOT change.
REQ-025 SHALL add each payload byte to the checksum on its transfer edge only.
REQ-026 Latency: a word accepted at edge t0 in IDLE SHALL produce the header on dout_vld after edge t0+1, with dout_rdy held at 1.
REQ-027 With dout_rdy=1 and input always available, SHALL sustain one byte per cycle within a frame; IDLE costs at least one cycle between frames.
REQ-028 The next frame's first word MAY be accepted during SUM; it SHALL be held until HEAD->HI.

Reset
REQ-029 While rst_n=0, SHALL drive b_rdy=0, dout=0, dout_vld=0, dout_sop=0, dout_eop=0, with state=IDLE, word_full=0, checksum=0 and counter=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately, with no eop; after release the next frame SHALL start with a fresh header.
REQ-031 b_rdy SHALL first rise on the first rising edge after rst_n deasserts.

Verification
REQ-032 PKT_WORDS=4; words 1234, ABCD, 0001, FF00; dout_rdy=1 -> bytes 55 12 34 AB CD 00 01 FF 00 BE, with sop on 55 and eop on BE.
REQ-033 Same data; dout_rdy toggles 1/0 each cycle -> identical byte sequence; dout is stable during every stall; no byte is duplicated or dropped.
REQ-034 din_vld pulses only every 5th cycle -> dout_vld=0 in HI gaps; b_rdy=0 while word_full=1; output is the same as in REQ-032.
REQ-035 din_vld=1 with a changing din while b_rdy=0 -> only words captured with b_rdy=1 appear in the output.
REQ-036 Reset pulse after 5 bytes of a frame -> all outputs are 0 during reset; the next frame, words 0000 x4, gives 55 00 00 00 00 00 00 00 00 00.
REQ-037 Two back-to-back frames with dout_rdy=1 -> the second sop follows the first eop after exactly one idle cycle; both checksums are correct.
